// File: rtl/au_pkg.sv
// Shared AU definitions: operand/result widths, mode encodings, checker FSM states
// and the packed transaction layout used for the first-error and error-log records.
package au_pkg;

  localparam int A_W         = 4;
  localparam int MODE_W      = 3;
  localparam int RES_W       = 5;
  localparam int FIRST_ERR_W = MODE_W + 2 * A_W + RES_W;
  localparam int ERR_W       = FIRST_ERR_W + RES_W;

  // Mode encodings are {S,Cin}
  localparam logic [MODE_W-1:0] AU_ADD   = 3'd0;
  localparam logic [MODE_W-1:0] AU_ADD_C = 3'd1;
  localparam logic [MODE_W-1:0] AU_SUB_B = 3'd2;
  localparam logic [MODE_W-1:0] AU_SUB   = 3'd3;
  localparam logic [MODE_W-1:0] AU_PASS  = 3'd4;
  localparam logic [MODE_W-1:0] AU_INC   = 3'd5;
  localparam logic [MODE_W-1:0] AU_DEC   = 3'd6;
  localparam logic [MODE_W-1:0] AU_ONE_A = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } chk_state_e;

  typedef struct packed {
    logic [MODE_W-1:0] mode;
    logic [A_W-1:0]    a;
    logic [A_W-1:0]    b;
    logic [RES_W-1:0]  result;
  } au_txn_t;

endpackage

// File: rtl/au_golden_model.sv
// Combinational reference AU: {a,b,mode} -> 5-bit {Cout,D}, operands zero-extended
// so bit 4 carries instead of wrapping modulo 16.
module au_golden_model
  import au_pkg::*;
(
  input  logic [A_W-1:0]    a_i,
  input  logic [A_W-1:0]    b_i,
  input  logic [MODE_W-1:0] mode_i,
  output logic [RES_W-1:0]  exp_o
);

  logic [RES_W-1:0] a_x;
  logic [RES_W-1:0] b_x;
  logic [RES_W-1:0] nb_x;

  assign a_x  = {1'b0, a_i};
  assign b_x  = {1'b0, b_i};
  // B is inverted at 4 bits before extension, so bit 4 of ~B is always 0
  assign nb_x = {1'b0, ~b_i};

  always_comb begin
    exp_o = '0;
    case (mode_i)
      AU_ADD:   exp_o = a_x + b_x;
      AU_ADD_C: exp_o = a_x + b_x + RES_W'(1);
      AU_SUB_B: exp_o = a_x + nb_x;
      AU_SUB:   exp_o = a_x + nb_x + RES_W'(1);
      AU_PASS:  exp_o = a_x;
      AU_INC:   exp_o = a_x + RES_W'(1);
      AU_DEC:   exp_o = a_x + RES_W'(15);
      AU_ONE_A: exp_o = {1'b1, a_i};
      default:  exp_o = '0;
    endcase
  end

endmodule

// File: rtl/au_response_checker.sv
// Clocked scoreboard for the AU stimulus stream: registers each accepted transaction,
// compares it with au_golden_model one edge later, and keeps pass/fail statistics.
// Optional mismatch-log FIFO enabled by defining AU_CHK_ERRLOG_EN.
module au_response_checker
  import au_pkg::*;
#(
  parameter int NUM_VECTORS = 2048,
  parameter int CNT_W       = 12,
  parameter int ERR_DEPTH   = 4
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [A_W-1:0]         in_a,
  input  logic [A_W-1:0]         in_b,
  input  logic [MODE_W-1:0]      in_mode,
  input  logic [RES_W-1:0]       in_result,
  output logic [CNT_W-1:0]       pass_cnt,
  output logic [CNT_W-1:0]       fail_cnt,
  output logic                   done,
`ifdef AU_CHK_ERRLOG_EN
  output logic                   err_valid,
  input  logic                   err_pop,
  output logic [ERR_W-1:0]       err_data,
  output logic                   err_ovf,
`endif
  output logic [FIRST_ERR_W-1:0] first_err,
  output logic [RES_W-1:0]       first_exp
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_VECTORS);

  chk_state_e             state_q;
  logic                   ready_q;
  logic                   done_q;
  logic [CNT_W-1:0]       acc_cnt_q;
  logic                   pipe_vld_q;
  au_txn_t                pipe_q;

  logic [CNT_W-1:0]       pass_q,      pass_d;
  logic [CNT_W-1:0]       fail_q,      fail_d;
  logic [FIRST_ERR_W-1:0] first_err_q, first_err_d;
  logic [RES_W-1:0]       first_exp_q, first_exp_d;

  logic [RES_W-1:0]       exp_w;
  logic                   start_run;
  logic                   accept;
  logic                   commit;
  logic                   mismatch;
  logic                   last_accept;
  logic                   last_commit;
  logic [CNT_W-1:0]       checked_nxt;

  au_golden_model u_golden (
    .a_i    (pipe_q.a),
    .b_i    (pipe_q.b),
    .mode_i (pipe_q.mode),
    .exp_o  (exp_w)
  );

  // ready_q is only ever set in RUN, so accept implies RUN
  assign start_run   = start && (state_q != ST_RUN);
  assign accept      = in_valid && ready_q;
  assign commit      = pipe_vld_q && (state_q == ST_RUN);
  assign mismatch    = commit && (pipe_q.result != exp_w);
  assign last_accept = accept && ((acc_cnt_q + CNT_W'(1)) == LAST_CNT);
  assign checked_nxt = pass_q + fail_q + CNT_W'(1);
  assign last_commit = commit && (checked_nxt == LAST_CNT);

  // Control FSM with registered in_ready/done
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      acc_cnt_q  <= '0;
      pipe_vld_q <= 1'b0;
      pipe_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q    <= ST_RUN;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            acc_cnt_q  <= '0;
            pipe_vld_q <= 1'b0;
          end
        end
        ST_RUN: begin
          pipe_vld_q <= accept;
          if (accept) begin
            pipe_q    <= '{mode: in_mode, a: in_a, b: in_b, result: in_result};
            acc_cnt_q <= acc_cnt_q + CNT_W'(1);
          end
          if (last_accept) begin
            ready_q <= 1'b0;
          end
          if (last_commit) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          ready_q    <= 1'b0;
          pipe_vld_q <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    pass_d      = pass_q;
    fail_d      = fail_q;
    first_err_d = first_err_q;
    first_exp_d = first_exp_q;
    if (start_run) begin
      pass_d      = '0;
      fail_d      = '0;
      first_err_d = '0;
      first_exp_d = '0;
    end else if (commit) begin
      if (mismatch) begin
        fail_d = fail_q + CNT_W'(1);
        if (fail_q == '0) begin
          first_err_d = pipe_q;
          first_exp_d = exp_w;
        end
      end else begin
        pass_d = pass_q + CNT_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments; blocking ones are reserved for always_comb.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pass_q      <= '0;
      fail_q      <= '0;
      first_err_q <= '0;
      first_exp_q <= '0;
    end else begin
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      first_err_q <= first_err_d;
      first_exp_q <= first_exp_d;
    end
  end

  assign in_ready  = ready_q;
  assign done      = done_q;
  assign pass_cnt  = pass_q;
  assign fail_cnt  = fail_q;
  assign first_err = first_err_q;
  assign first_exp = first_exp_q;

`ifdef AU_CHK_ERRLOG_EN
  // Mismatch log; ERR_DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
  localparam int             PTR_W    = (ERR_DEPTH > 1) ? $clog2(ERR_DEPTH) : 1;
  localparam logic [PTR_W:0] ERR_FULL = (PTR_W + 1)'(ERR_DEPTH);

  logic [ERR_W-1:0] err_mem_q [ERR_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   err_cnt_q;
  logic             ovf_q;
  logic             err_full;
  logic             do_pop;
  logic             do_push;

  assign err_full = (err_cnt_q == ERR_FULL);
  assign do_pop   = err_pop && (err_cnt_q != '0);
  // A pop in the same cycle frees the slot, so a push into a full log still lands
  assign do_push  = mismatch && (!err_full || do_pop);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      err_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else if (start_run) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      err_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   err_cnt_q <= err_cnt_q + (PTR_W + 1)'(1);
        2'b01:   err_cnt_q <= err_cnt_q - (PTR_W + 1)'(1);
        default: err_cnt_q <= err_cnt_q;
      endcase
      if (mismatch && !do_push) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // NOTE: log storage is not reset; the pointers and count alone decide which entries are live.
  always_ff @(posedge CLK) begin
    if (do_push) begin
      err_mem_q[wr_ptr_q] <= {pipe_q, exp_w};
    end
  end

  assign err_valid = (err_cnt_q != '0);
  assign err_data  = err_mem_q[rd_ptr_q];
  assign err_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_au_response_checker.sv
// Self-checking bench for au_response_checker: directed steps plus random traffic
// scored against an arithmetic reference model of the AU and the run bookkeeping.
module tb_au_response_checker;

  localparam int NV = 2048;
  localparam int CW = 12;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_a;
  logic [3:0]    in_b;
  logic [2:0]    in_mode;
  logic [4:0]    in_result;
  logic [CW-1:0] pass_cnt;
  logic [CW-1:0] fail_cnt;
  logic          done;
  logic [15:0]   first_err;
  logic [4:0]    first_exp;
`ifdef AU_CHK_ERRLOG_EN
  logic          err_valid;
  logic          err_pop;
  logic [20:0]   err_data;
  logic          err_ovf;
  logic [20:0]   log_q[$];
`endif

  int tests = 0;
  int fails = 0;

  // Reference model state: 0 = idle, 1 = run (run complete once NV compares are counted)
  int          m_phase;
  int          m_acc;
  int          m_pass;
  int          m_fail;
  logic [15:0] m_ferr;
  logic [4:0]  m_fexp;

  au_response_checker #(
    .NUM_VECTORS (NV),
    .CNT_W       (CW),
    .ERR_DEPTH   (4)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_mode   (in_mode),
    .in_result (in_result),
    .pass_cnt  (pass_cnt),
    .fail_cnt  (fail_cnt),
    .done      (done),
`ifdef AU_CHK_ERRLOG_EN
    .err_valid (err_valid),
    .err_pop   (err_pop),
    .err_data  (err_data),
    .err_ovf   (err_ovf),
`endif
    .first_err (first_err),
    .first_exp (first_exp)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic int ref_golden(input int a, input int b, input int m);
    case (m)
      0:       return a + b;
      1:       return a + b + 1;
      2:       return a + (15 - b);
      3:       return a + (15 - b) + 1;
      4:       return a;
      5:       return a + 1;
      6:       return a + 15;
      default: return 16 + a;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_acc  = 0;
    m_pass = 0;
    m_fail = 0;
    m_ferr = '0;
    m_fexp = '0;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge CLK);
    if (m_phase != 1 || (m_acc == NV && m_pass + m_fail == NV)) begin
      model_clear();
      m_phase = 1;
    end
    #1 start = 1'b0;
  endtask

  task automatic push(input int a, input int b, input int m, input int r);
    logic [4:0] e;
    in_valid  = 1'b1;
    in_a      = 4'(a);
    in_b      = 4'(b);
    in_mode   = 3'(m);
    in_result = 5'(r);
    @(posedge CLK);
    if (m_phase == 1 && m_acc < NV) begin
      m_acc++;
      e = 5'(ref_golden(a, b, m));
      if (5'(r) == e) begin
        m_pass++;
      end else begin
        if (m_fail == 0) begin
          m_ferr = {3'(m), 4'(a), 4'(b), 5'(r)};
          m_fexp = e;
        end
        m_fail++;
      end
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic push_rand_good();
    int a, b, m;
    a = int'($urandom_range(15));
    b = int'($urandom_range(15));
    m = int'($urandom_range(7));
    push(a, b, m, ref_golden(a, b, m));
  endtask

  task automatic check_model(input string tag);
    check({tag, "_pass"},  pass_cnt,  m_pass);
    check({tag, "_fail"},  fail_cnt,  m_fail);
    check({tag, "_ferr"},  first_err, m_ferr);
    check({tag, "_fexp"},  first_exp, m_fexp);
  endtask

  initial begin
    int a, b, m, r;
    int b2;

    RST_N     = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_mode   = '0;
    in_result = '0;
`ifdef AU_CHK_ERRLOG_EN
    err_pop   = 1'b0;
`endif
    m_phase   = 0;
    model_clear();
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;
    idle();

    // Reset state
    check("rst_ready", in_ready,  0);
    check("rst_done",  done,      0);
    check("rst_pass",  pass_cnt,  0);
    check("rst_fail",  fail_cnt,  0);
    check("rst_ferr",  first_err, 0);
    check("rst_fexp",  first_exp, 0);

    do_start();
    check("start_ready", in_ready, 1);

    // 9 + 8 in mode 0: committed two edges after presentation
    push(9, 8, 0, 'h11);
    check("t1_latency_pass", pass_cnt, 0);
    idle();
    check("t1_pass", pass_cnt, 1);
    check("t1_fail", fail_cnt, 0);

    // mode 7 pass then fail; first_err captures the failing vector
    b2 = int'($urandom_range(15));
    push(3, b2, 7, 'h13);
    push(3, b2, 7, 'h03);
    idle();
    check("t2_pass", pass_cnt, 2);
    check("t2_fail", fail_cnt, 1);
    check("t2_ferr", first_err, {3'd7, 4'h3, 4'(b2), 5'h03});
    check("t2_fexp", first_exp, 5'h13);

    // Random traffic with gaps and occasional wrong results
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(3) == 0) begin
        idle();
      end else begin
        a = int'($urandom_range(15));
        b = int'($urandom_range(15));
        m = int'($urandom_range(7));
        r = ($urandom_range(3) == 0) ? int'($urandom_range(31)) : ref_golden(a, b, m);
        push(a, b, m, r);
      end
    end
    idle();
    check_model("rand");

    // start while running is ignored
    do_start();
    idle();
    check("run_start_pass",  pass_cnt, m_pass);
    check("run_start_ready", in_ready, 1);

    // Complete the run: ready drops on the last accept, done one edge later
    while (m_acc < NV) push_rand_good();
    check("fill_ready_drop", in_ready, 0);
    check("fill_done_early", done, 0);
    idle();
    check("fill_done", done, 1);
    check_model("fill");
    check("fill_total", pass_cnt + fail_cnt, NV);

    // Traffic in DONE is ignored
    push(1, 2, 0, 0);
    idle();
    check("done_ignore_pass", pass_cnt, m_pass);
    check("done_ignore_fail", fail_cnt, m_fail);
    check("done_ignore_ready", in_ready, 0);

    // Restart from DONE clears statistics
    do_start();
    check("restart_pass",  pass_cnt,  0);
    check("restart_fail",  fail_cnt,  0);
    check("restart_ferr",  first_err, 0);
    check("restart_done",  done,      0);
    check("restart_ready", in_ready,  1);

    // mode 2 5+~3 = 0x11 passes; mode 6 0+15 with wrong result is logged
    b2 = int'($urandom_range(15));
    push(5, 3, 2, 'h11);
    push(0, b2, 6, 'h0E);
    idle();
    check("t4_pass", pass_cnt, 1);
    check("t4_fail", fail_cnt, 1);
    check("t4_ferr", first_err, {3'd6, 4'h0, 4'(b2), 5'h0E});
    check("t4_fexp", first_exp, 5'h0F);

    // Reset in the middle of a run with a transaction in the pipe
    while (m_acc < 100) push_rand_good();
    idle();
    check_model("pre_rst");
    a = int'($urandom_range(15));
    in_valid  = 1'b1;
    in_a      = 4'(a);
    in_b      = 4'h1;
    in_mode   = 3'd0;
    in_result = 5'(a + 1);
    @(posedge CLK);
    #1 RST_N = 1'b0;
    #1;
    check("mid_rst_ready", in_ready,  0);
    check("mid_rst_done",  done,      0);
    check("mid_rst_pass",  pass_cnt,  0);
    check("mid_rst_fail",  fail_cnt,  0);
    check("mid_rst_ferr",  first_err, 0);
    check("mid_rst_fexp",  first_exp, 0);
    m_phase = 0;
    model_clear();
    in_valid = 1'b0;
    @(posedge CLK);
    #1 RST_N = 1'b1;
    idle();
    check("post_rst_idle_ready", in_ready, 0);
    check("post_rst_pass", pass_cnt, 0);

    // Full counter sweep of {S,Cin,A,B} with a correct AU
    do_start();
    for (int i = 0; i < NV; i++) begin
      a = (i >> 4) & 15;
      b = i & 15;
      m = (i >> 8) & 7;
      push(a, b, m, ref_golden(a, b, m));
    end
    check("sweep_ready_drop", in_ready, 0);
    check("sweep_done_early", done, 0);
    idle();
    check("sweep_pass",  pass_cnt, NV);
    check("sweep_fail",  fail_cnt, 0);
    check("sweep_done",  done,     1);
    check("sweep_ready", in_ready, 0);
    push(15, 15, 1, 0);
    idle();
    check("sweep_extra_pass", pass_cnt, NV);
    check("sweep_extra_fail", fail_cnt, 0);

`ifdef AU_CHK_ERRLOG_EN
    // Five mismatches into a four-deep log: first four kept in order, overflow flagged
    do_start();
    check("log_clear_valid", err_valid, 0);
    check("log_clear_ovf",   err_ovf,   0);
    log_q.delete();
    for (int i = 0; i < 5; i++) begin
      a = int'($urandom_range(15));
      b = int'($urandom_range(15));
      m = int'($urandom_range(7));
      r = ref_golden(a, b, m) ^ 1;
      if (i < 4) log_q.push_back({3'(m), 4'(a), 4'(b), 5'(r), 5'(ref_golden(a, b, m))});
      push(a, b, m, r);
    end
    idle();
    check("log_fail",  fail_cnt,  5);
    check("log_valid", err_valid, 1);
    check("log_ovf",   err_ovf,   1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("log_entry%0d", k), err_data, log_q[k]);
      err_pop = 1'b1;
      @(posedge CLK);
      #1 err_pop = 1'b0;
    end
    check("log_empty", err_valid, 0);
    check("log_ovf_sticky", err_ovf, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
